// File: rtl/branch_feedback_queue.sv
// -----------------------------------------------------------------------------
// branch_feedback_queue
//
// Holds the branch predictions that fetch has made and not yet resolved, in
// program order. When the oldest branch resolves, its stored prediction is
// paired with the actual outcome. That pair is registered and handed back to
// the predictor's feedback port as a single-cycle pulse.
//
// A mispredicted resolve squashes every younger entry, because those entries
// came from the wrong path. An external flush also squashes every entry.
//
// Parameters
//   DEPTH       in-flight entries (power of two, 2..16)
//   ADDR_WIDTH  PC width
//
// Ports
//   clk, rst                       clock, async active-high reset
//   i_push_valid / o_push_ready    record a prediction (pc + three predictions)
//   i_push_pc, i_push_prediction*  final / local / global predictions
//   i_resolve_valid, _outcome      the oldest branch resolved, with its outcome
//   i_flush                        discard all entries
//   o_fb_*                         registered feedback, valid for one cycle
//   o_mispredict                   feedback entry was mispredicted
//   o_count                        occupancy
//   o_underflow                    sticky: a resolve arrived while empty
// -----------------------------------------------------------------------------
module branch_feedback_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push_valid,
   output logic                         o_push_ready,
   input  logic [ADDR_WIDTH-1:0]        i_push_pc,
   input  logic                         i_push_prediction,
   input  logic                         i_push_prediction1,
   input  logic                         i_push_prediction2,
   input  logic                         i_resolve_valid,
   input  logic                         i_resolve_outcome,
   input  logic                         i_flush,
   output logic                         o_fb_valid,
   output logic [ADDR_WIDTH-1:0]        o_fb_pc,
   output logic                         o_fb_prediction,
   output logic                         o_fb_outcome,
   output logic                         o_fb_prediction1,
   output logic                         o_fb_prediction2,
   output logic                         o_mispredict,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  pred;
      logic                  pred1;
      logic                  pred2;
   } entry_t;

   // Entry storage is not reset. The occupancy count alone decides which
   // slots hold live entries.
   entry_t mem_q [DEPTH];

   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  fb_valid_q, fb_valid_d;
   logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
   logic                  fb_pred_q, fb_pred_d;
   logic                  fb_pred1_q, fb_pred1_d;
   logic                  fb_pred2_q, fb_pred2_d;
   logic                  fb_outcome_q, fb_outcome_d;
   logic                  mispredict_q, mispredict_d;
   logic                  underflow_q, underflow_d;

   entry_t head;
   entry_t push_entry;
   logic   push_ready;
   logic   do_resolve;
   logic   head_mispred;
   logic   squash;
   logic   push_ok;

   // Ready comes from registered occupancy only. A full queue stays not-ready
   // even while it is resolving, so there is no comb path from resolve to ready.
   assign push_ready   = (count_q != CNT_W'(DEPTH));
   assign head         = mem_q[rd_ptr_q];
   assign push_entry   = '{pc: i_push_pc, pred: i_push_prediction,
                           pred1: i_push_prediction1, pred2: i_push_prediction2};
   assign do_resolve   = i_resolve_valid && (count_q != '0);
   assign head_mispred = head.pred != i_resolve_outcome;

   // On a wrong-path squash, a push in the same cycle is also wrong-path.
   assign squash       = i_flush || (do_resolve && head_mispred);
   assign push_ok      = i_push_valid && push_ready && !squash;

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      fb_valid_d   = do_resolve;
      fb_pc_d      = fb_pc_q;
      fb_pred_d    = fb_pred_q;
      fb_pred1_d   = fb_pred1_q;
      fb_pred2_d   = fb_pred2_q;
      fb_outcome_d = fb_outcome_q;
      mispredict_d = do_resolve && head_mispred;
      underflow_d  = underflow_q || (i_resolve_valid && (count_q == '0));

      // Feedback data is loaded only on a real resolve, so it holds between pulses.
      if (do_resolve) begin
         fb_pc_d      = head.pc;
         fb_pred_d    = head.pred;
         fb_pred1_d   = head.pred1;
         fb_pred2_d   = head.pred2;
         fb_outcome_d = i_resolve_outcome;
      end

      if (squash) begin
         // Empty the queue by aligning the read pointer with the write pointer.
         // The squashed push never advances the write pointer.
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (do_resolve) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
         case ({push_ok, do_resolve})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         fb_valid_q   <= 1'b0;
         fb_pc_q      <= '0;
         fb_pred_q    <= 1'b0;
         fb_pred1_q   <= 1'b0;
         fb_pred2_q   <= 1'b0;
         fb_outcome_q <= 1'b0;
         mispredict_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fb_valid_q   <= fb_valid_d;
         fb_pc_q      <= fb_pc_d;
         fb_pred_q    <= fb_pred_d;
         fb_pred1_q   <= fb_pred1_d;
         fb_pred2_q   <= fb_pred2_d;
         fb_outcome_q <= fb_outcome_d;
         mispredict_q <= mispredict_d;
         underflow_q  <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   assign o_push_ready     = push_ready;
   assign o_count          = count_q;
   assign o_fb_valid       = fb_valid_q;
   assign o_fb_pc          = fb_pc_q;
   assign o_fb_prediction  = fb_pred_q;
   assign o_fb_prediction1 = fb_pred1_q;
   assign o_fb_prediction2 = fb_pred2_q;
   assign o_fb_outcome     = fb_outcome_q;
   assign o_mispredict     = mispredict_q;
   assign o_underflow      = underflow_q;

endmodule
